mult_share_sched: RTL and testbench



---
 rtl/mult_share_sched.sv | 198 +++++++++++++++++++
 tb/tb_mult_share_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// Shares one carry-save multiplier between NREQ valid/ready requesters through a 3-stage stallable pipeline.
// Define MULT_SHARE_FIXPRIO_EN for fixed-priority arbitration (lowest index wins) instead of round-robin.

module csa3 #(
  parameter int W = 34
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
endmodule

module csa_chain #(
  parameter int W = 34,
  parameter int K = 2
) (
  input  logic [K-1:0][W-1:0] rows,
  output logic [W-1:0]        sum_vec,
  output logic [W-1:0]        carry_vec
);
  logic [W-1:0] s_arr [1:K-1];
  logic [W-1:0] c_arr [1:K-1];

  assign s_arr[1] = rows[0];
  assign c_arr[1] = rows[1];

  for (genvar gi = 2; gi < K; gi++) begin : g_stage
    csa3 #(.W(W)) u_csa (
      .x(s_arr[gi-1]),
      .y(c_arr[gi-1]),
      .z(rows[gi]),
      .s(s_arr[gi]),
      .c(c_arr[gi])
    );
  end

  assign sum_vec   = s_arr[K-1];
  assign carry_vec = c_arr[K-1];
endmodule

module mult #(
  parameter int N    = 17,
  parameter int M    = 17,
  parameter int MULT = 0
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] out1,
  output logic [N+M-1:0] out2
);
  localparam int W = N + M;
  localparam int R = M + 1;
  localparam int H = R / 2;

  logic [W-1:0]        a_ext;
  logic [R-1:0][W-1:0] pp;

  assign a_ext = {{M{a[N-1]}}, a};

  for (genvar gi = 0; gi < M - 1; gi++) begin : g_pp
    assign pp[gi] = b[gi] ? (a_ext << gi) : '0;
  end
  // The b sign bit weighs -2^(M-1): add ~x here and the +1 completing the negation as an extra row.
  assign pp[M-1] = b[M-1] ? ~(a_ext << (M - 1)) : '0;
  assign pp[M]   = {{(W-1){1'b0}}, b[M-1]};

  if (MULT == 0) begin : g_wallace
    logic [W-1:0] lo_s, lo_c, hi_s, hi_c, mid_s, mid_c;
    // Two half-height chains in parallel, merged by a 4:2 stage.
    csa_chain #(.W(W), .K(H))     u_lo (.rows(pp[H-1:0]), .sum_vec(lo_s), .carry_vec(lo_c));
    csa_chain #(.W(W), .K(R - H)) u_hi (.rows(pp[R-1:H]), .sum_vec(hi_s), .carry_vec(hi_c));
    csa3 #(.W(W)) u_m0 (.x(lo_s), .y(lo_c), .z(hi_s), .s(mid_s), .c(mid_c));
    csa3 #(.W(W)) u_m1 (.x(mid_s), .y(mid_c), .z(hi_c), .s(out1), .c(out2));
  end else begin : g_dadda
    csa_chain #(.W(W), .K(R)) u_all (.rows(pp), .sum_vec(out1), .carry_vec(out2));
  end
endmodule

module mult_share_sched #(
  parameter int N    = 17,
  parameter int M    = 17,
  parameter int NREQ = 4,
  parameter int MULT = 0,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_a,
  input  logic [NREQ*M-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [N+M-1:0]     rsp_data,
  output logic               busy
);
  logic [N-1:0]   a_reg;
  logic [M-1:0]   b_reg;
  logic [IDW-1:0] id1_reg, id2_reg, id3_reg;
  logic           v1_reg, v2_reg, v3_reg;
  logic [N+M-1:0] out1_reg, out2_reg, sum_reg;
  logic [N+M-1:0] m_out1, m_out2;

  logic           adv, hs;
  logic [IDW-1:0] win_id;

  // Gating with rst_n keeps req_ready at zero for as long as reset is held.
  assign adv = rst_n & (~v3_reg | rsp_ready);
  assign hs  = adv & (|req_valid);

`ifdef MULT_SHARE_FIXPRIO_EN
  always_comb begin
    win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) win_id = k[IDW-1:0];
    end
  end
`else
  logic [IDW-1:0]  ptr_reg, ptr_next;
  logic [NREQ-1:0] hi_mask;
  logic [IDW-1:0]  win_hi, win_lo;

  // Requesters at or above ptr win first; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_mask = req_valid & ~((NREQ'(1) << ptr_reg) - NREQ'(1));
    win_hi  = '0;
    win_lo  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hi_mask[k])   win_hi = k[IDW-1:0];
      if (req_valid[k]) win_lo = k[IDW-1:0];
    end
    win_id = (|hi_mask) ? win_hi : win_lo;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (hs) ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end
`endif

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[win_id] = 1'b1;
  end

  mult #(.N(N), .M(M), .MULT(MULT)) u_mult (
    .a(a_reg),
    .b(b_reg),
    .out1(m_out1),
    .out2(m_out2)
  );

  // All three stages move together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      id1_reg  <= '0;
      v1_reg   <= 1'b0;
      out1_reg <= '0;
      out2_reg <= '0;
      id2_reg  <= '0;
      v2_reg   <= 1'b0;
      sum_reg  <= '0;
      id3_reg  <= '0;
      v3_reg   <= 1'b0;
    end else if (adv) begin
      v1_reg <= hs;
      if (hs) begin
        a_reg   <= req_a[win_id*N +: N];
        b_reg   <= req_b[win_id*M +: M];
        id1_reg <= win_id;
      end
      out1_reg <= m_out1;
      out2_reg <= m_out2;
      id2_reg  <= id1_reg;
      v2_reg   <= v1_reg;
      sum_reg  <= out1_reg + out2_reg;
      id3_reg  <= id2_reg;
      v3_reg   <= v2_reg;
    end
  end

  assign rsp_valid = v3_reg;
  assign rsp_id    = id3_reg;
  assign rsp_data  = sum_reg;
  assign busy      = v1_reg | v2_reg | v3_reg;
endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a queue-based reference model checked every cycle.
module tb_mult_share_sched;
  localparam int N = 17;
  localparam int M = 17;
  localparam int NREQ = 4;
  localparam int W = N + M;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*M-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  mult_share_sched #(.N(N), .M(M), .NREQ(NREQ), .MULT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [N-1:0] a; logic [M-1:0] b; } op_t;
  typedef struct { int id; int cyc; } grant_t;
  typedef struct { int id; logic [W-1:0] data; int cyc; } rsp_t;
  typedef struct { int id; logic [W-1:0] prod; int rem; } exp_t;

  op_t    pend[$];
  grant_t grant_log[$];
  rsp_t   rsp_log[$];
  exp_t   mq[$];
  int     mptr = 0;
  int     checks = 0;
  int     errors = 0;
  int     cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int m_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (((v >> idx) & NREQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  // Driver and transaction log: pops granted operands, then presents the next head per requester.
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_log.push_back('{i, cycle});
        $display("grant id=%0d cycle=%0d", i, cycle);
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].id == i) begin
            pend.delete(j);
            break;
          end
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      rsp_log.push_back('{int'(rsp_id), rsp_data, cycle});
      $display("rsp id=%0d data=%0d cycle=%0d", rsp_id, $signed(rsp_data), cycle);
    end
    cycle++;
    #1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].id == i) begin
          req_valid[i] = 1'b1;
          req_a[i*N +: N] = pend[j].a;
          req_b[i*M +: M] = pend[j].b;
          break;
        end
      end
    end
  end

  // Reference model: in-flight products with the number of advances left before they show.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mptr = 0;
    end else begin : model_step
      bit vis, adv;
      int g;
      logic [N-1:0] a;
      logic [M-1:0] b;
      logic signed [W-1:0] p;
      vis = (mq.size() > 0) && (mq[0].rem == 0);
      adv = !vis || rsp_ready;
      if (adv) begin
        if (vis) void'(mq.pop_front());
        foreach (mq[i]) mq[i].rem = mq[i].rem - 1;
        g = m_winner(req_valid, mptr);
        if (g >= 0) begin
          a = req_a[g*N +: N];
          b = req_b[g*M +: M];
          p = $signed(a) * $signed(b);
          mq.push_back('{g, p, 2});
`ifndef MULT_SHARE_FIXPRIO_EN
          mptr = (g + 1) % NREQ;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin : cmp
      bit vis, adv;
      int g;
      logic [NREQ-1:0] exp_rr;
      vis = (mq.size() > 0) && (mq[0].rem == 0);
      adv = !vis || rsp_ready;
      g = m_winner(req_valid, mptr);
      exp_rr = (adv && g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      chk("rsp_valid", 64'(rsp_valid), 64'(vis));
      chk("busy", 64'(busy), 64'(mq.size() > 0));
      if (vis) begin
        chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(mq[0].prod));
      end
    end
  end

  task automatic wait_grants(input int target, input string name);
    int c = 0;
    while (grant_log.size() < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (grant_log.size() < target) timeout_fail(name);
  endtask

  task automatic wait_rsps(input int target, input string name);
    int c = 0;
    while (rsp_log.size() < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (rsp_log.size() < target) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    @(negedge clk);
    while ((busy || pend.size() > 0) && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (busy || pend.size() > 0) timeout_fail(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int gb, rb, cnt;
    logic [W-1:0] held_data;
    logic [1:0]   held_id;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_id", 64'(rsp_id), 64'd0);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Fairness: all requesters held valid for 12 grants.
    gb = grant_log.size();
    rb = rsp_log.size();
    for (int k = 0; k < 12; k++)
      for (int i = 0; i < NREQ; i++)
        pend.push_back('{i, 17'(i * 100 + k + 1), 17'(k - 3)});
    wait_grants(gb + 12, "rr grants");
    pend.delete();
    req_valid = '0;
    for (int k = 0; k < 12 && gb + k < grant_log.size(); k++) begin
`ifdef MULT_SHARE_FIXPRIO_EN
      chk($sformatf("grant order %0d", k), 64'(grant_log[gb+k].id), 64'd0);
`else
      chk($sformatf("grant order %0d", k), 64'(grant_log[gb+k].id), 64'(k % 4));
`endif
    end
    wait_idle("rr drain");
    for (int i = 0; i < NREQ; i++) begin
      cnt = 0;
      for (int j = rb; j < rsp_log.size(); j++) if (rsp_log[j].id == i) cnt++;
`ifdef MULT_SHARE_FIXPRIO_EN
      chk($sformatf("rr count id%0d", i), 64'(cnt), (i == 0) ? 64'd12 : 64'd0);
`else
      chk($sformatf("rr count id%0d", i), 64'(cnt), 64'd3);
`endif
    end

    // Single request: 3 * -5 from requester 2.
    gb = grant_log.size();
    rb = rsp_log.size();
    pend.push_back('{2, 17'd3, 17'h1FFFB});
    wait_rsps(rb + 1, "single rsp");
    if (rsp_log.size() > rb && grant_log.size() > gb) begin
      chk("single grant id", 64'(grant_log[gb].id), 64'd2);
      chk("single rsp id", 64'(rsp_log[rb].id), 64'd2);
      chk("single rsp data", 64'(rsp_log[rb].data), 64'(34'h3_FFFF_FFF1));
      chk("single latency", 64'(rsp_log[rb].cyc - grant_log[gb].cyc), 64'd3);
    end
    wait_idle("single drain");

    // Corner operands.
    rb = rsp_log.size();
    pend.push_back('{0, 17'h10000, 17'h10000});
    pend.push_back('{1, 17'h0FFFF, 17'h10000});
    pend.push_back('{3, 17'h00000, 17'h1FFFF});
    wait_rsps(rb + 3, "corner rsps");
    for (int j = rb; j < rsp_log.size(); j++) begin
      case (rsp_log[j].id)
        0: chk("corner min*min", 64'(rsp_log[j].data), 64'(34'h1_0000_0000));
        1: chk("corner max*min", 64'(rsp_log[j].data), 64'(34'h3_0001_0000));
        default: chk("corner zero*neg1", 64'(rsp_log[j].data), 64'd0);
      endcase
    end
    wait_idle("corner drain");

    // Backpressure: six requests, output stalled for five cycles.
    rb = rsp_log.size();
    for (int k = 0; k < 6; k++) pend.push_back('{k % 4, 17'(1000 + k * 37), 17'(-(k * 11) - 2)});
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!rsp_valid) timeout_fail("bp first rsp");
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id = rsp_id;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp rsp_data stable", 64'(rsp_data), 64'(held_data));
      chk("bp rsp_id stable", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    wait_rsps(rb + 6, "bp rsps");
    wait_idle("bp drain");
    chk("bp rsp count", 64'(rsp_log.size() - rb), 64'd6);

    // Back-to-back issue with the output always ready.
    gb = grant_log.size();
    rb = rsp_log.size();
    for (int k = 0; k < 8; k++) pend.push_back('{k % 4, 17'(k * 513 + 7), 17'(k * 3 - 9)});
    wait_rsps(rb + 8, "b2b rsps");
    if (rsp_log.size() >= rb + 8 && grant_log.size() >= gb + 8) begin
      chk("b2b grant span", 64'(grant_log[gb+7].cyc - grant_log[gb].cyc), 64'd7);
      chk("b2b first latency", 64'(rsp_log[rb].cyc - grant_log[gb].cyc), 64'd3);
      chk("b2b rsp span", 64'(rsp_log[rb+7].cyc - rsp_log[rb].cyc), 64'd7);
    end
    wait_idle("b2b drain");

    // Reset with three entries in flight.
    gb = grant_log.size();
    for (int k = 0; k < 3; k++) pend.push_back('{k, 17'(k + 20), 17'(k + 5)});
    wait_grants(gb + 3, "rst fill");
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) pend.push_back('{i, 17'(i + 40), 17'(-(i + 1))});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst req_ready", 64'(req_ready), 64'd0);
    chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst rsp_id", 64'(rsp_id), 64'd0);
    chk("midrst rsp_data", 64'(rsp_data), 64'd0);
    repeat (2) @(negedge clk);
    gb = grant_log.size();
    rb = rsp_log.size();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    wait_grants(gb + 1, "post-reset grant");
    if (grant_log.size() > gb) chk("post-reset first grant", 64'(grant_log[gb].id), 64'd0);
    wait_idle("post-reset drain");
    chk("post-reset rsp count", 64'(rsp_log.size() - rb), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
